// File: rtl/game_input_mmio.sv
`default_nettype none
// =============================================================================
// game_input_mmio : debounced N-channel input port, edge capture, IRQ and
//                   timestamped event FIFO behind an Avalon-MM slave.
// Revision        : 1.0
// =============================================================================

module game_input_mmio #(
  parameter int N_CH        = 5,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEB_W       = 20,
  parameter int DEB_DEFAULT = 50000,
  parameter int TS_DIV      = 1000
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic [N_CH-1:0] pio_in,
  input  logic [2:0]      mmo_address,
  input  logic [31:0]     mmo_writedata,
  input  logic [3:0]      mmo_byteenable,
  input  logic            mmo_read,
  input  logic            mmo_write,
  output logic [31:0]     mmo_readdata,
  output logic            irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

  localparam logic [2:0] ADDR_LEVEL     = 3'd0;
  localparam logic [2:0] ADDR_EDGE      = 3'd1;
  localparam logic [2:0] ADDR_MASK      = 3'd2;
  localparam logic [2:0] ADDR_FIFO_DATA = 3'd3;
  localparam logic [2:0] ADDR_FIFO_STAT = 3'd4;
  localparam logic [2:0] ADDR_CTRL      = 3'd5;
  localparam logic [2:0] ADDR_DEBOUNCE  = 3'd6;
  localparam logic [2:0] ADDR_TSTAMP    = 3'd7;

  // input path
  logic [N_CH-1:0]  sync1, sync2, stable, toggle;
  logic [DEB_W-1:0] debounce_q, deb_lim;

  // timestamp
  logic [PW-1:0]    ts_pre;
  logic [23:0]      tstamp;

  // control / status registers
  logic [N_CH-1:0]  edge_q, mask_q;
  logic             en, fifo_irq_en, ovf;

  // event capture and arbitration
  logic [N_CH-1:0]  pending, pol, new_evt, arb_onehot;
  logic [23:0]      ts_lat [N_CH];
  logic             arb_valid;
  logic [31:0]      arb_word;
  logic             lost_pend;

  // fifo
  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, push, pop, drop;

  // bus decode
  logic             wr_en, rd_en;
  logic [31:0]      be_mask, wdata_m, rd_mux;
  logic             flush, ovf_clr;
  logic [N_CH-1:0]  edge_clr;

  assign wr_en   = mmo_write;
  assign rd_en   = mmo_read & ~mmo_write;
  assign be_mask = {{8{mmo_byteenable[3]}}, {8{mmo_byteenable[2]}},
                    {8{mmo_byteenable[1]}}, {8{mmo_byteenable[0]}}};
  assign wdata_m = mmo_writedata & be_mask;

  assign flush    = wr_en && (mmo_address == ADDR_CTRL) && wdata_m[1];
  assign ovf_clr  = wr_en && (mmo_address == ADDR_FIFO_STAT) && wdata_m[16];
  assign edge_clr = (wr_en && (mmo_address == ADDR_EDGE)) ? wdata_m[N_CH-1:0] : '0;

  // A programmed DEBOUNCE of 0 behaves like 1.
  assign deb_lim = (debounce_q == '0) ? '0 : debounce_q - 1'b1;

  // ---------------------------------------------------------------------------
  // Synchroniser, debounce and stable level
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
    end else begin
      sync1  <= pio_in;
      sync2  <= sync1;
      stable <= stable ^ toggle;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DEB_W-1:0] cnt;

    // >= rather than == so lowering DEBOUNCE mid-count still resolves.
    assign toggle[i] = (sync2[i] != stable[i]) && (cnt >= deb_lim);

    always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
        cnt <= '0;
      end else if ((sync2[i] == stable[i]) || toggle[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Timestamp
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      ts_pre <= '0;
      tstamp <= '0;
    end else if (ts_pre == PW'(TS_DIV - 1)) begin
      ts_pre <= '0;
      tstamp <= tstamp + 24'd1;
    end else begin
      ts_pre <= ts_pre + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      edge_q      <= '0;
      mask_q      <= '0;
      en          <= 1'b0;
      fifo_irq_en <= 1'b0;
      debounce_q  <= DEB_W'(DEB_DEFAULT);
      ovf         <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | toggle;
      if (wr_en && (mmo_address == ADDR_MASK))
        mask_q <= (mask_q & ~be_mask[N_CH-1:0]) | wdata_m[N_CH-1:0];
      if (wr_en && (mmo_address == ADDR_CTRL) && mmo_byteenable[0]) begin
        en          <= mmo_writedata[0];
        fifo_irq_en <= mmo_writedata[2];
      end
      if (wr_en && (mmo_address == ADDR_DEBOUNCE))
        debounce_q <= (debounce_q & ~be_mask[DEB_W-1:0]) | wdata_m[DEB_W-1:0];
      if (flush)
        ovf <= 1'b0;
      else
        ovf <= (ovf & ~ovf_clr) | lost_pend | drop;
    end
  end

  // ---------------------------------------------------------------------------
  // Event capture and lowest-index-first arbitration
  // ---------------------------------------------------------------------------
  assign new_evt = toggle & {N_CH{en}};
  // A channel being pushed this cycle has made room, so its re-arm is no loss.
  assign lost_pend = |(new_evt & pending & ~arb_onehot);

  always_comb begin
    arb_valid  = 1'b0;
    arb_onehot = '0;
    arb_word   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        arb_valid     = 1'b1;
        arb_onehot    = '0;
        arb_onehot[i] = 1'b1;
        arb_word      = {1'b1, pol[i], 6'(i), ts_lat[i]};
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pending <= '0;
      pol     <= '0;
      for (int i = 0; i < N_CH; i++) ts_lat[i] <= '0;
    end else begin
      pending <= flush ? '0 : ((pending & ~arb_onehot) | new_evt);
      for (int i = 0; i < N_CH; i++) begin
        if (new_evt[i]) begin
          pol[i]    <= sync2[i];
          ts_lat[i] <= tstamp;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = rd_en && (mmo_address == ADDR_FIFO_DATA) && (count != '0);
  assign push = arb_valid && (!full || pop) && !flush;
  assign drop = arb_valid && full && !pop && !flush;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= arb_word;
  end

  // ---------------------------------------------------------------------------
  // Read path and interrupt
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (mmo_address)
      ADDR_LEVEL:     rd_mux[N_CH-1:0] = stable;
      ADDR_EDGE:      rd_mux[N_CH-1:0] = edge_q;
      ADDR_MASK:      rd_mux[N_CH-1:0] = mask_q;
      ADDR_FIFO_DATA: if (count != '0) rd_mux = mem[rd_ptr];
      ADDR_FIFO_STAT: begin
        rd_mux[CW-1:0] = count;
        rd_mux[16]     = ovf;
      end
      ADDR_CTRL: begin
        rd_mux[0] = en;
        rd_mux[2] = fifo_irq_en;
      end
      ADDR_DEBOUNCE:  rd_mux[DEB_W-1:0] = debounce_q;
      ADDR_TSTAMP:    rd_mux[23:0] = tstamp;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      mmo_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      mmo_readdata <= rd_en ? rd_mux : '0;
      irq          <= (|(edge_q & mask_q)) | (fifo_irq_en & (count != '0)) | (fifo_irq_en & ovf);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{be_mask, wdata_m, mmo_writedata};

endmodule

`default_nettype wire

// File: tb/tb_game_input_mmio.sv
`default_nettype none
// Self-checking bench for game_input_mmio: register table plus directed
// sequences for debounce latency, event ordering, overflow, flush and reset.

module tb_game_input_mmio;

  localparam int N_CH  = 5;
  localparam int DEPTH = 16;
  localparam int TSDIV = 8;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [4:0]  pio_in;
  logic [2:0]  mmo_address;
  logic [31:0] mmo_writedata;
  logic [3:0]  mmo_byteenable;
  logic        mmo_read;
  logic        mmo_write;
  logic [31:0] mmo_readdata;
  logic        irq;

  game_input_mmio #(
    .N_CH(N_CH), .FIFO_DEPTH(DEPTH), .DEB_W(20), .DEB_DEFAULT(50000), .TS_DIV(TSDIV)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .pio_in         (pio_in),
    .mmo_address    (mmo_address),
    .mmo_writedata  (mmo_writedata),
    .mmo_byteenable (mmo_byteenable),
    .mmo_read       (mmo_read),
    .mmo_write      (mmo_write),
    .mmo_readdata   (mmo_readdata),
    .irq            (irq)
  );

  always #5 clk_clk = ~clk_clk;

  typedef enum int {OP_W, OP_R, OP_RW} op_e;
  typedef struct {
    op_e         op;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] q[$];
  logic       exp_ovf;
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic void add(op_e op, logic [2:0] a, logic [31:0] d, logic [3:0] be,
                              logic [31:0] e, string n);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.be = be; v.exp = e; v.name = n;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk_clk);
    mmo_address = a; mmo_writedata = d; mmo_byteenable = be; mmo_write = 1'b1;
    @(negedge clk_clk);
    mmo_write = 1'b0; mmo_byteenable = 4'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    mmo_address = a; mmo_read = 1'b1;
    @(negedge clk_clk);
    mmo_read = 1'b0;
    d = mmo_readdata;
  endtask

  task automatic read_check(input logic [2:0] a, input logic [31:0] e, input string n);
    logic [31:0] d;
    bus_read(a, d);
    check(n, d, e);
  endtask

  // Toggle pins and record the events the FIFO should hold (ascending channel order).
  task automatic toggle_pins(input logic [4:0] m);
    @(negedge clk_clk);
    pio_in = pio_in ^ m;
    for (int c = 0; c < N_CH; c++) begin
      if (m[c]) begin
        if (q.size() < DEPTH) q.push_back({1'b1, pio_in[c], 6'(c)});
        else exp_ovf = 1'b1;
      end
    end
    idle(14);
  endtask

  initial begin
    logic [31:0] d, t1, t2;
    logic [31:0] w [3];
    int first, n;

    reset_reset_n = 1'b0; pio_in = '0; mmo_address = '0; mmo_writedata = '0;
    mmo_byteenable = '0; mmo_read = 1'b0; mmo_write = 1'b0; exp_ovf = 1'b0;
    idle(4);
    reset_reset_n = 1'b1;
    check("rst_readdata", mmo_readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // ---- register table ----
    add(OP_R,  3'd0, 32'h0,         4'h0, 32'h0,        "rst_level");
    add(OP_R,  3'd1, 32'h0,         4'h0, 32'h0,        "rst_edge");
    add(OP_R,  3'd2, 32'h0,         4'h0, 32'h0,        "rst_mask");
    add(OP_R,  3'd3, 32'h0,         4'h0, 32'h0,        "rst_fifo_data");
    add(OP_R,  3'd4, 32'h0,         4'h0, 32'h0,        "rst_fifo_stat");
    add(OP_R,  3'd5, 32'h0,         4'h0, 32'h0,        "rst_ctrl");
    add(OP_R,  3'd6, 32'h0,         4'h0, 32'd50000,    "rst_debounce");
    add(OP_W,  3'd2, 32'hFFFF_FFFF, 4'hF, 32'h0,        "");
    add(OP_R,  3'd2, 32'h0,         4'h0, 32'h1F,       "mask_unused_bits");
    add(OP_W,  3'd2, 32'h0,         4'h0, 32'h0,        "");
    add(OP_R,  3'd2, 32'h0,         4'h0, 32'h1F,       "mask_be_none");
    add(OP_W,  3'd2, 32'h0,         4'h1, 32'h0,        "");
    add(OP_R,  3'd2, 32'h0,         4'h0, 32'h0,        "mask_be_lane0");
    add(OP_W,  3'd6, 32'h1234_5678, 4'h3, 32'h0,        "");
    add(OP_R,  3'd6, 32'h0,         4'h0, 32'h0000_5678,"deb_lanes01");
    add(OP_W,  3'd6, 32'hFFFF_FFFF, 4'h4, 32'h0,        "");
    add(OP_R,  3'd6, 32'h0,         4'h0, 32'h000F_5678,"deb_lane2_width");
    add(OP_W,  3'd6, 32'h4,         4'hF, 32'h0,        "");
    add(OP_R,  3'd6, 32'h0,         4'h0, 32'h4,        "deb_set4");
    add(OP_W,  3'd0, 32'hFF,        4'hF, 32'h0,        "");
    add(OP_R,  3'd0, 32'h0,         4'h0, 32'h0,        "level_ro");
    add(OP_W,  3'd5, 32'h7,         4'hF, 32'h0,        "");
    add(OP_R,  3'd5, 32'h0,         4'h0, 32'h5,        "ctrl_flush_reads0");
    add(OP_W,  3'd5, 32'h0,         4'hF, 32'h0,        "");
    add(OP_R,  3'd5, 32'h0,         4'h0, 32'h0,        "ctrl_clear");
    add(OP_RW, 3'd2, 32'h3,         4'hF, 32'h0,        "rw_readdata0");
    add(OP_R,  3'd2, 32'h0,         4'h0, 32'h3,        "rw_write_done");
    add(OP_W,  3'd2, 32'h0,         4'hF, 32'h0,        "");

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_W: bus_write(tbl[i].addr, tbl[i].data, tbl[i].be);
        OP_R: read_check(tbl[i].addr, tbl[i].exp, tbl[i].name);
        default: begin
          @(negedge clk_clk);
          mmo_address = tbl[i].addr; mmo_writedata = tbl[i].data;
          mmo_byteenable = tbl[i].be; mmo_write = 1'b1; mmo_read = 1'b1;
          @(negedge clk_clk);
          mmo_write = 1'b0; mmo_read = 1'b0; mmo_byteenable = 4'h0;
          check(tbl[i].name, mmo_readdata, tbl[i].exp);
        end
      endcase
    end

    // ---- timestamp advances once per TSDIV cycles ----
    bus_read(3'd7, t1);
    idle(78);
    bus_read(3'd7, t2);
    check("tstamp_rate", t2 - t1, 32'd10);

    // ---- debounce latency: stable changes 6 edges after the pin; bus shows it one edge later ----
    @(negedge clk_clk);
    pio_in[0] = 1'b1; mmo_address = 3'd0; mmo_read = 1'b1;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_clk);
      if (first == 0 && mmo_readdata[0]) first = k;
    end
    mmo_read = 1'b0;
    check("deb_latency", 32'(first), 32'd7);
    read_check(3'd1, 32'h01, "edge_pin0");
    check("irq_masked", {31'b0, irq}, 32'h0);
    read_check(3'd4, 32'h0, "no_evt_when_disabled");
    bus_write(3'd1, 32'h1, 4'hF);
    read_check(3'd1, 32'h0, "edge_w1c");

    // ---- glitch shorter than DEBOUNCE ----
    @(negedge clk_clk); pio_in[1] = 1'b1;
    idle(3);            pio_in[1] = 1'b0;
    idle(12);
    read_check(3'd0, 32'h01, "glitch_level");
    read_check(3'd1, 32'h00, "glitch_edge");

    // ---- three simultaneous rising events ----
    @(negedge clk_clk); pio_in = 5'b00000;
    idle(10);
    bus_write(3'd1, 32'h1F, 4'hF);
    bus_write(3'd5, 32'h1, 4'hF);
    @(negedge clk_clk); pio_in = 5'b10101;
    idle(12);
    read_check(3'd4, 32'd3, "evt_count3");
    for (int k = 0; k < 3; k++) bus_read(3'd3, w[k]);
    check("evt0_hdr", {24'b0, w[0][31:24]}, 32'hC0);
    check("evt1_hdr", {24'b0, w[1][31:24]}, 32'hC2);
    check("evt2_hdr", {24'b0, w[2][31:24]}, 32'hC4);
    check("evt_ts_eq01", {8'b0, w[1][23:0]}, {8'b0, w[0][23:0]});
    check("evt_ts_eq02", {8'b0, w[2][23:0]}, {8'b0, w[0][23:0]});
    bus_read(3'd7, t1);
    check("evt_ts_past", {31'b0, (w[0][23:0] <= t1[23:0]) && (w[0][23:0] != 24'd0)}, 32'd1);
    read_check(3'd3, 32'h0, "evt_empty_read");
    read_check(3'd4, 32'h0, "evt_count0");

    // ---- edge IRQ, byteenable on W1C, FIFO IRQ ----
    bus_write(3'd1, 32'h1F, 4'hF);
    bus_write(3'd2, 32'h04, 4'hF);
    idle(2);
    check("irq_idle", {31'b0, irq}, 32'h0);
    @(negedge clk_clk); pio_in[2] = 1'b0;
    idle(10);
    check("irq_edge2", {31'b0, irq}, 32'h1);
    bus_write(3'd1, 32'h04, 4'h0);
    read_check(3'd1, 32'h04, "edge_be0_kept");
    check("irq_still", {31'b0, irq}, 32'h1);
    bus_write(3'd1, 32'h04, 4'h1);
    read_check(3'd1, 32'h00, "edge_be1_clr");
    check("irq_cleared", {31'b0, irq}, 32'h0);
    bus_write(3'd5, 32'h5, 4'hF);
    idle(2);
    check("irq_fifo", {31'b0, irq}, 32'h1);
    bus_write(3'd2, 32'h0, 4'hF);
    bus_write(3'd5, 32'h3, 4'hF);
    idle(2);
    check("irq_after_flush", {31'b0, irq}, 32'h0);
    read_check(3'd4, 32'h0, "flush_empty");

    // ---- overflow: 17 events into a 16-deep FIFO ----
    q.delete(); exp_ovf = 1'b0;
    for (int r = 0; r < 3; r++) toggle_pins(5'h1F);
    toggle_pins(5'h01);
    toggle_pins(5'h02);
    read_check(3'd4, {15'b0, exp_ovf, 7'b0, 9'(q.size())}, "ovf_stat");
    n = q.size();
    for (int k = 0; k < n; k++) begin
      bus_read(3'd3, d);
      check($sformatf("ovf_evt%0d", k), {24'b0, d[31:24]}, {24'b0, q.pop_front()});
    end
    read_check(3'd3, 32'h0, "ovf_17th_read");
    read_check(3'd4, 32'h0001_0000, "ovf_sticky");
    bus_write(3'd4, 32'h0001_0000, 4'h3);
    read_check(3'd4, 32'h0001_0000, "ovf_be_wrong_lane");
    bus_write(3'd4, 32'h0001_0000, 4'h4);
    read_check(3'd4, 32'h0, "ovf_w1c");

    // ---- flush with a same-cycle toggle ----
    q.delete();
    toggle_pins(5'h1F);
    read_check(3'd4, 32'd5, "flush_pre5");
    @(negedge clk_clk); pio_in[3] = ~pio_in[3];
    idle(5);
    mmo_address = 3'd5; mmo_writedata = 32'h3; mmo_byteenable = 4'h1; mmo_write = 1'b1;
    @(negedge clk_clk);
    mmo_write = 1'b0; mmo_byteenable = 4'h0;
    idle(10);
    read_check(3'd4, 32'h0, "flush_stat");
    read_check(3'd3, 32'h0, "flush_evt_lost");
    read_check(3'd0, {27'b0, pio_in}, "flush_level");

    // ---- reset mid-debounce with a read in flight ----
    @(negedge clk_clk); pio_in = ~pio_in;
    idle(3);
    reset_reset_n = 1'b0; mmo_address = 3'd0; mmo_read = 1'b1;
    @(negedge clk_clk);
    reset_reset_n = 1'b1; mmo_read = 1'b0;
    check("rst_read_lost", mmo_readdata, 32'h0);
    idle(20);
    read_check(3'd0, 32'h0, "rst_mid_level");
    read_check(3'd6, 32'd50000, "rst_mid_debounce");
    read_check(3'd5, 32'h0, "rst_mid_ctrl");
    read_check(3'd1, 32'h0, "rst_mid_edge");
    check("rst_mid_irq", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
